// File: rtl/io_rx_fifo_mark_pkg.sv
// Shared definitions for the RX framing buffer: input FSM states and tag bit positions.
package io_rx_fifo_mark_pkg;

  typedef enum logic {
    RX_IDLE     = 1'b0,
    RX_IN_FRAME = 1'b1
  } rx_state_e;

  // Tags sit directly above the payload in each stored entry.
  function automatic int sof_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int eof_bit(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/io_rx_fifo_mark_fifo.sv
// io_generic_fifo: circular buffer with element count. A push is accepted
// when full if the head is popped in the same cycle.
module io_generic_fifo #(
  parameter int DATA_WIDTH       = 34,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clr_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  input  logic                        valid_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        ready_o
);

  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST  = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
  localparam logic [LOG_BUFFER_DEPTH:0]   FULL  = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);
  localparam logic [LOG_BUFFER_DEPTH-1:0] P_ONE = LOG_BUFFER_DEPTH'(1);
  localparam logic [LOG_BUFFER_DEPTH:0]   C_ONE = (LOG_BUFFER_DEPTH + 1)'(1);

  logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] r_wptr;
  logic [LOG_BUFFER_DEPTH-1:0] r_rptr;
  logic [LOG_BUFFER_DEPTH:0]   r_cnt;
  logic                        w_push;
  logic                        w_pop;

  assign valid_o    = (r_cnt != '0);
  assign w_pop      = valid_o & ready_i;
  assign ready_o    = (r_cnt != FULL) | w_pop;
  assign w_push     = valid_i & ready_o;
  assign data_o     = r_mem[r_rptr];
  assign elements_o = r_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + P_ONE;
      if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + P_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/io_rx_fifo_mark.sv
// RX framing buffer: stores {eof,sof,data}, drains by req/gnt, flags framing errors.
// Optional frame length counter enabled by IO_RX_FIFO_FRAME_LEN_EN.
module io_rx_fifo_mark
  import io_rx_fifo_mark_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clr_i,
  input  logic                        valid_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        sof_i,
  input  logic                        eof_i,
  output logic                        ready_o,
  output logic                        req_o,
  input  logic                        gnt_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        sof_o,
  output logic                        eof_o,
  output logic                        sof_evt_o,
  output logic                        eof_evt_o,
  output logic [LOG_BUFFER_DEPTH:0]   frames_o,
  output logic                        err_o,
  output logic [LEN_WIDTH-1:0]        frame_len_o
);

  localparam int SOF = sof_bit(DATA_WIDTH);
  localparam int EOF = eof_bit(DATA_WIDTH);
  localparam logic [LOG_BUFFER_DEPTH:0] F_ONE = (LOG_BUFFER_DEPTH + 1)'(1);

  logic [DATA_WIDTH+1:0]     w_wdata;
  logic [DATA_WIDTH+1:0]     w_rdata;
  logic [LOG_BUFFER_DEPTH:0] w_elements;
  logic                      w_ready;
  logic                      w_req;
  logic                      w_push;
  logic                      w_pop;

  rx_state_e                 r_state;
  logic                      r_err;
  logic [LOG_BUFFER_DEPTH:0] r_frames;
  logic                      r_sof_evt;
  logic                      r_eof_evt;

  assign w_wdata = {eof_i, sof_i, data_i};
  assign w_push  = valid_i & w_ready;
  assign w_pop   = w_req & gnt_i;

  io_generic_fifo #(
    .DATA_WIDTH       (DATA_WIDTH + 2),
    .BUFFER_DEPTH     (BUFFER_DEPTH),
    .LOG_BUFFER_DEPTH (LOG_BUFFER_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (clr_i),
    .elements_o (w_elements),
    .data_o     (w_rdata),
    .valid_o    (w_req),
    .ready_i    (gnt_i),
    .valid_i    (valid_i),
    .data_i     (w_wdata),
    .ready_o    (w_ready)
  );

  assign ready_o   = w_ready;
  assign req_o     = w_req;
  assign data_o    = w_rdata[DATA_WIDTH-1:0];
  assign sof_o     = w_rdata[SOF];
  assign eof_o     = w_rdata[EOF];
  assign sof_evt_o = r_sof_evt;
  assign eof_evt_o = r_eof_evt;
  assign frames_o  = r_frames;
  assign err_o     = r_err;

  // Input framing FSM; only accepted words advance it, every word is stored.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= RX_IDLE;
      r_err   <= 1'b0;
    end else if (clr_i) begin
      r_state <= RX_IDLE;
      r_err   <= 1'b0;
    end else if (w_push) begin
      if (sof_i && r_state == RX_IN_FRAME)          r_err <= 1'b1;
      if (eof_i && !sof_i && r_state == RX_IDLE)    r_err <= 1'b1;
      if (sof_i && !eof_i)                          r_state <= RX_IN_FRAME;
      else if (eof_i)                               r_state <= RX_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frames  <= '0;
      r_sof_evt <= 1'b0;
      r_eof_evt <= 1'b0;
    end else if (clr_i) begin
      r_frames  <= '0;
      r_sof_evt <= 1'b0;
      r_eof_evt <= 1'b0;
    end else begin
      r_sof_evt <= w_pop & w_rdata[SOF];
      r_eof_evt <= w_pop & w_rdata[EOF];
      case ({w_push & eof_i, w_pop & w_rdata[EOF]})
        2'b10:   r_frames <= r_frames + F_ONE;
        2'b01:   r_frames <= r_frames - F_ONE;
        default: r_frames <= r_frames;
      endcase
    end
  end

  // Every eof-tagged word counted here is still in the buffer.
  a_frames_le_elements: assert property (@(posedge clk_i) disable iff (!rstn_i)
    r_frames <= w_elements);

`ifdef IO_RX_FIFO_FRAME_LEN_EN
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [LEN_WIDTH-1:0] L_ONE   = LEN_WIDTH'(1);

  logic [LEN_WIDTH-1:0] r_len_cnt;
  logic [LEN_WIDTH-1:0] r_frame_len;
  logic [LEN_WIDTH-1:0] w_len_next;

  assign w_len_next  = w_rdata[SOF] ? L_ONE :
                       (r_len_cnt == LEN_MAX) ? r_len_cnt : r_len_cnt + L_ONE;
  assign frame_len_o = r_frame_len;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_len_cnt   <= '0;
      r_frame_len <= '0;
    end else if (clr_i) begin
      r_len_cnt   <= '0;
    end else if (w_pop) begin
      if (w_rdata[EOF]) begin
        r_frame_len <= w_len_next;
        r_len_cnt   <= '0;
      end else begin
        r_len_cnt   <= w_len_next;
      end
    end
  end
`else
  assign frame_len_o = '0;
`endif

endmodule

// File: tb/tb_io_rx_fifo_mark.sv
// Randomized bench for io_rx_fifo_mark against a queue-based reference model.
module tb_io_rx_fifo_mark;

  localparam int DW  = 32;
  localparam int D   = 4;
  localparam int LD  = $clog2(D);
  localparam int LW  = 16;
  localparam int LEN_MAX = (1 << LW) - 1;

  logic          clk_i = 1'b0;
  logic          rstn_i, clr_i, valid_i, sof_i, eof_i, gnt_i;
  logic [DW-1:0] data_i;
  logic          ready_o, req_o, sof_o, eof_o, sof_evt_o, eof_evt_o, err_o;
  logic [DW-1:0] data_o;
  logic [LD:0]   frames_o;
  logic [LW-1:0] frame_len_o;

  io_rx_fifo_mark #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .valid_i(valid_i),
    .data_i(data_i), .sof_i(sof_i), .eof_i(eof_i), .ready_o(ready_o),
    .req_o(req_o), .gnt_i(gnt_i), .data_o(data_o), .sof_o(sof_o),
    .eof_o(eof_o), .sof_evt_o(sof_evt_o), .eof_evt_o(eof_evt_o),
    .frames_o(frames_o), .err_o(err_o), .frame_len_o(frame_len_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: queue of {eof,sof,data} words plus framing bookkeeping.
  logic [DW+1:0] q[$];
  bit m_err, m_inframe, m_sevt, m_eevt;
  int m_cnt, m_flen;

  function automatic int eof_words();
    int n = 0;
    foreach (q[i]) if (q[i][DW+1]) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_err = 0; m_inframe = 0; m_sevt = 0; m_eevt = 0; m_cnt = 0; m_flen = 0;
  endtask

  task automatic check_outputs();
    chk("req", req_o, q.size() > 0);
    if (q.size() > 0) begin
      chk("data", data_o, q[0][DW-1:0]);
      chk("sof_o", sof_o, q[0][DW]);
      chk("eof_o", eof_o, q[0][DW+1]);
    end
    chk("frames", frames_o, eof_words());
    chk("err", err_o, m_err);
    chk("sof_evt", sof_evt_o, m_sevt);
    chk("eof_evt", eof_evt_o, m_eevt);
`ifdef IO_RX_FIFO_FRAME_LEN_EN
    chk("frame_len", frame_len_o, m_flen);
`else
    chk("frame_len", frame_len_o, 0);
`endif
  endtask

  bit hold = 0;

  task automatic run(input int cycles, input int gnt_pct, input int vld_pct, input int clr_pct);
    bit exp_ready, push, pop;
    logic [DW+1:0] head;
    int n;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      check_outputs();
      if (!hold) begin
        int r = $urandom_range(0, 99);
        valid_i = ($urandom_range(0, 99) < vld_pct);
        data_i  = $urandom;
        sof_i   = (r < 20) || (r >= 40 && r < 50);
        eof_i   = (r >= 20 && r < 50);
      end
      gnt_i = ($urandom_range(0, 99) < gnt_pct);
      clr_i = ($urandom_range(0, 99) < clr_pct);
      #1;
      exp_ready = (q.size() < D) || (gnt_i && q.size() > 0);
      chk("ready", ready_o, exp_ready);
      hold = valid_i && !exp_ready && !clr_i;
      if (clr_i) begin
        q.delete();
        m_err = 0; m_inframe = 0; m_sevt = 0; m_eevt = 0; m_cnt = 0;
      end else begin
        pop  = (q.size() > 0) && gnt_i;
        push = valid_i && exp_ready;
        m_sevt = 0; m_eevt = 0;
        if (pop) begin
          head = q.pop_front();
          m_sevt = head[DW]; m_eevt = head[DW+1];
          n = head[DW] ? 1 : (m_cnt < LEN_MAX ? m_cnt + 1 : m_cnt);
          if (head[DW+1]) begin m_flen = n; m_cnt = 0; end
          else m_cnt = n;
        end
        if (push) begin
          if (sof_i && m_inframe) m_err = 1;
          if (eof_i && !sof_i && !m_inframe) m_err = 1;
          if (sof_i && !eof_i) m_inframe = 1;
          else if (eof_i) m_inframe = 0;
          q.push_back({eof_i, sof_i, data_i});
        end
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk_i);
    check_outputs();
    rstn_i = 1'b0;
    valid_i = 0; gnt_i = 0; clr_i = 0; sof_i = 0; eof_i = 0; hold = 0;
    #1;
    model_reset();
    check_outputs();
    chk("ready_rst", ready_o, 1);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  initial begin
    rstn_i = 1'b0; clr_i = 0; valid_i = 0; sof_i = 0; eof_i = 0; gnt_i = 0; data_i = '0;
    model_reset();
    #1;
    check_outputs();
    chk("ready_rst", ready_o, 1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    run(400, 90, 60, 0);
    run(400, 15, 90, 0);
    run(400, 50, 70, 2);
    async_reset();
    run(300, 40, 80, 1);
    async_reset();
    run(300, 85, 85, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
